// File: rtl/fp_pkg.sv
// Shared IEEE754 single-precision definitions: field widths, class encoding
// and the classifier used by the result collector and later stages.
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CLASS_W = 3;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [CLASS_W-1:0] {
        ZERO = 3'd0,
        SUBN = 3'd1,
        NORM = 3'd2,
        INF  = 3'd3,
        QNAN = 3'd4,
        SNAN = 3'd5
    } fp_class_t;

    typedef struct packed {
        fp_class_t         cls;
        logic [WORD_W-1:0] data;
    } fp_entry_t;

    function automatic fp_class_t fp_classify(input logic [WORD_W-1:0] w);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        fp_class_t        c;
        e = w[30:23];
        m = w[22:0];
        if (e == '0) begin
            c = (m == '0) ? ZERO : SUBN;
        end else if (e != EXP_MAX) begin
            c = NORM;
        end else if (m == '0) begin
            c = INF;
        end else if (m[MAN_W-1]) begin
            c = QNAN;
        end else begin
            c = SNAN;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Generic first-word-fall-through FIFO; head word is visible whenever not
// empty and reads as zero when empty.
module fp_sync_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_c = (count == '0);
    assign full_c  = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty_c;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push & (~full_c | do_pop);
    assign rdata_c = empty_c ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// Captures multiplier results on the rising edge of done, tags them with
// their IEEE754 class and queues them for a valid/ready consumer.
module fp_result_collector
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   done_in,
    input  logic [31:0]            res_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   out_sign,
    output logic [2:0]             out_class,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int unsigned ENTRY_W = $bits(fp_entry_t);

    logic               done_q;
    logic               push_c;
    logic               pop_c;
    logic               drop_c;
    logic               empty_c;
    fp_entry_t          wentry;
    fp_entry_t          head;
    logic [ENTRY_W-1:0] rdata_c;

    // done_q resets high so a done level present at reset release is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= done_in;
        end
    end

    assign push_c = done_in & ~done_q;
    assign pop_c  = out_valid & out_ready;
    assign drop_c = push_c & full & ~pop_c;

    assign wentry.cls  = fp_classify(res_in);
    assign wentry.data = res_in;

    fp_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   (wentry),
        .rdata_c (rdata_c),
        .count   (count),
        .full_c  (full),
        .empty_c (empty_c)
    );

    assign head      = fp_entry_t'(rdata_c);
    assign out_valid = ~empty_c;
    assign out_data  = head.data;
    assign out_sign  = head.data[31];
    assign out_class = 3'(head.cls);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop_c && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector with hand-computed expectations.
module tb_fp_result_collector;

    logic        clk;
    logic        rst;
    logic        done_in;
    logic [31:0] res_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sign;
    logic [2:0]  out_class;
    logic [2:0]  count;
    logic        full;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    fp_result_collector #(.DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .res_in    (res_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sign  (out_sign),
        .out_class (out_class),
        .count     (count),
        .full      (full),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] v);
        done_in = 1'b1;
        res_in  = v;
        tick();
        done_in = 1'b0;
        tick();
    endtask

    task automatic chk_head(input string tag, input logic [31:0] d, input logic s, input logic [2:0] c);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  out_data, d);
        chk({tag, "_sign"},  32'(out_sign), 32'(s));
        chk({tag, "_class"}, 32'(out_class), 32'(c));
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        done_in   = 1'b0;
        res_in    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_drop",  32'(drop_cnt), 32'd0);
        rst = 1'b1;
        tick();

        // Single pulse, one-cycle latency
        done_in = 1'b1;
        res_in  = 32'h40A00000;
        tick();
        done_in = 1'b0;
        chk_head("t1", 32'h40A00000, 1'b0, 3'd2);
        chk("t1_count", 32'(count), 32'd1);
        pop_one();
        chk("t1_empty_valid", 32'(out_valid), 32'd0);
        chk("t1_empty_data",  out_data, 32'd0);
        chk("t1_empty_class", 32'(out_class), 32'd0);

        // Signed zero and infinity
        pulse(32'h80000000);
        pulse(32'hFF800000);
        chk("t2_count", 32'(count), 32'd2);
        chk_head("t2_h0", 32'h80000000, 1'b1, 3'd0);
        out_ready = 1'b1;
        tick();
        chk_head("t2_h1", 32'hFF800000, 1'b1, 3'd3);
        tick();
        out_ready = 1'b0;
        chk("t2_after_valid", 32'(out_valid), 32'd0);
        chk("t2_after_count", 32'(count), 32'd0);

        // NaN kinds and subnormal, in FIFO order
        pulse(32'h7FC00000);
        pulse(32'h7F800001);
        pulse(32'h00000001);
        chk("t3_count", 32'(count), 32'd3);
        chk_head("t3_q", 32'h7FC00000, 1'b0, 3'd4);
        pop_one();
        chk_head("t3_s", 32'h7F800001, 1'b0, 3'd5);
        pop_one();
        chk_head("t3_sub", 32'h00000001, 1'b0, 3'd1);
        pop_one();
        chk("t3_empty", 32'(out_valid), 32'd0);

        // Held done level captures once, with rising-cycle data
        done_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            res_in = 32'h3F800000 + 32'(i);
            tick();
        end
        done_in = 1'b0;
        tick();
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_data", out_data, 32'h3F800000);
        pop_one();
        chk("t4_empty", 32'(count), 32'd0);

        // Overflow drops, simultaneous push/pop while full
        for (int i = 1; i <= 6; i++) pulse(32'h41000000 + 32'(i));
        chk("t5_full",  32'(full), 32'd1);
        chk("t5_count", 32'(count), 32'd4);
        chk("t5_drop",  32'(drop_cnt), 32'd2);
        chk("t5_head",  out_data, 32'h41000001);
        out_ready = 1'b1;
        done_in   = 1'b1;
        res_in    = 32'h41000007;
        tick();
        done_in   = 1'b0;
        out_ready = 1'b0;
        chk("t5_pp_count", 32'(count), 32'd4);
        chk("t5_pp_drop",  32'(drop_cnt), 32'd2);
        chk("t5_pp_head",  out_data, 32'h41000002);
        tick();

        // Drop counter saturation
        for (int i = 0; i < 260; i++) pulse(32'h42000000 + 32'(i));
        chk("sat_drop",  32'(drop_cnt), 32'd255);
        chk("sat_count", 32'(count), 32'd4);
        chk("sat_head",  out_data, 32'h41000002);
        pop_one();
        chk("sat_pop_head",  out_data, 32'h41000003);
        chk("sat_pop_count", 32'(count), 32'd3);
        chk("sat_pop_full",  32'(full), 32'd0);

        // Asynchronous flush with entries queued
        rst = 1'b0;
        #2;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_drop",  32'(drop_cnt), 32'd0);
        chk("t6_async_data",  out_data, 32'd0);
        done_in = 1'b1;
        res_in  = 32'h3F000000;
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("t6_release_count", 32'(count), 32'd0);
        done_in = 1'b0;
        tick();
        chk("t6_release_count2", 32'(count), 32'd0);
        pulse(32'h40000000);
        chk("t6_cap_count", 32'(count), 32'd1);
        chk("t6_cap_data",  out_data, 32'h40000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
Downstream stage of the IEEE754 single-precision multiplier (double_multipler).
- Captures each 32-bit result `res` when the multiplier asserts `done`.
- Classifies it: sign plus IEEE754 class.
- Buffers results in a small first-word-fall-through FIFO and presents them to a consumer over a valid/ready handshake.
- Counts results lost to a full FIFO.

Parameters:
- DEPTH, 4: FIFO entries. Must be a power of two, ≥2.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- rst  in  1  asynchronous, active-low reset.
- done_in  in  1  multiplier `done`. May be a pulse or a level.
- res_in  in  32  multiplier `res`. Valid in the cycle done_in first rises.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head when out_valid=1.
- out_data  out  32  head result word.
- out_sign  out  1  out_data[31].
- out_class  out  3  class of head entry (encoding below).
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count==DEPTH.
- drop_cnt  out  CNT_W  results dropped; saturating.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty and pointers 0.
  - out_valid=0, out_data=0, out_sign=0, out_class=0, count=0, full=0, drop_cnt=0.
  - done_q is forced to 1, so a done_in held high across reset release is NOT captured.
- Capture:
  - push = done_in & ~done_q, where done_q is done_in registered.
  - Only the 0→1 edge captures; a level held high for N cycles yields exactly one push.
  - res_in is sampled in the push cycle.
- Class encoding (computed at write time, stored with the word):
  - 0 ZERO: exp==0, man==0.
  - 1 SUBN: exp==0, man!=0.
  - 2 NORM: exp in 1..254.
  - 3 INF: exp==255, man==0.
  - 4 QNAN: exp==255, man[22]==1.
  - 5 SNAN: exp==255, man[22]==0, man!=0.
  - 6 and 7 are unused.
- Latency: push at edge N makes out_valid=1 from cycle N+1 (1 cycle) when the FIFO was empty.
- Pop: pop = out_valid & out_ready.
  - The head advances on the clock edge.
  - out_data, out_sign and out_class show the next entry, or 0 when the FIFO is empty.
- Outputs when empty: out_valid=0 and the data outputs are driven to 0. out_ready is ignored.
- Full, push with no pop: the word is dropped.
  - FIFO contents are unchanged.
  - drop_cnt increments, saturating at 2^CNT_W-1.
- Full, push and pop in the same cycle: both are performed. count is unchanged and nothing is dropped.
- Empty, push: the write happens; a pop is impossible that cycle.
- Pointers: wrap modulo DEPTH. count is updated +1 / -1 / 0 per cycle.
- Reset mid-operation: the FIFO is flushed immediately. Entries and drop_cnt are lost; the consumer sees out_valid fall asynchronously.
- No combinational path from out_ready or done_in to any output. All outputs are registered or decoded from registered state.

Decomposition:
- Package fp_pkg:
  - fp_class_t enum (ZERO, SUBN, NORM, INF, QNAN, SNAN).
  - Constants EXP_MAX=8'hFF, EXP_W=8, MAN_W=23.
  - Function fp_classify(logic [31:0]) returning fp_class_t, shared with future rounding/exception stages.
- Sub-module fp_sync_fifo (generic WIDTH/DEPTH FWFT FIFO with push/pop/count/full/empty).
  - Instantiated with WIDTH=35 (32 data + 3 class).
  - Edge detection, classification and drop counting stay in the top module.

Test Plan:
1. Reset, then a 1-cycle done_in pulse with res_in=0x40A00000 (5.0) → next cycle out_valid=1, out_data=0x40A00000, out_sign=0, out_class=NORM, count=1.
2. Push 0x80000000 (-0.0) then, on a later done edge, 0xFF800000 (-inf), with out_ready=0 → count=2; head is -0.0 with sign=1, class ZERO. Raise out_ready → -inf, sign=1, class INF. Next cycle out_valid=0.
3. Push 0x7FC00000, 0x7F800001, 0x00000001 → classes QNAN, SNAN, SUBN in FIFO order.
4. Hold done_in high for 10 cycles with res_in changing each cycle → exactly one entry, holding the value from the rising cycle.
5. DEPTH=4 with out_ready=0: 6 separate done pulses → full=1, count=4, drop_cnt=2, and the first 4 values are preserved. Then push with out_ready=1 while full → count stays 4, drop_cnt stays 2.
6. done_in held high while rst=0→1, then assert rst=0 with 3 entries queued → no capture at release. During reset out_valid=0, count=0, drop_cnt=0 asynchronously, with no clock edge needed.
